// File: rtl/pcie_lane_detect_tracker.sv
// Receiver-detect collector and link-width negotiator.
// Samples PIPE detect results, resolves a legal width, drops idle lanes.
module pcie_lane_detect_tracker #(
    parameter int MAX_NUM_LANES = 16,
    parameter int WINDOW_CYCLES = 64,
    parameter int IDLE_TIMEOUT  = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         detect_en_i,
    input  logic [MAX_NUM_LANES-1:0]     phy_phystatus_i,
    input  logic [3*MAX_NUM_LANES-1:0]   phy_rxstatus_i,
    input  logic [MAX_NUM_LANES-1:0]     phy_rxelecidle_i,
    output logic [MAX_NUM_LANES-1:0]     lane_status_o,
    output logic [5:0]                   num_active_lanes_o,
    output logic [5:0]                   link_width_o,
    output logic                         lane_reversed_o,
    output logic                         detect_done_o,
    output logic                         lane_lost_o
);

    localparam int N  = MAX_NUM_LANES;
    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE, S_COLLECT, S_EVAL, S_LOCKED
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_en_q;
    logic [WW-1:0]   r_win;
    logic [N-1:0]    r_lane;
    logic [5:0]      r_width;
    logic            r_rev;
    logic [5:0]      r_nact;
    logic            r_done;
    logic            r_lost;
    logic [IW-1:0]   r_idle_cnt [N];

    logic            w_rise;
    logic [N-1:0]    w_hit;
    logic [N-1:0]    w_drop;
    logic [5:0]      w_run0;
    logic [5:0]      w_runn;
    logic [5:0]      w_run;
    logic            w_go0;
    logic            w_gon;
    logic            w_rev;
    logic [5:0]      w_width;
    logic [N-1:0]    w_keep;
    logic [N-1:0]    w_trim;
    logic [5:0]      w_nact_trim;
    logic [5:0]      w_nact_full;

    assign w_rise = detect_en_i & ~r_en_q;

    always_comb begin
        w_hit  = '0;
        w_drop = '0;
        for (int i = 0; i < N; i++) begin
            w_hit[i]  = phy_phystatus_i[i]
                      && (phy_rxstatus_i[3*i +: 3] == 3'b011);
            w_drop[i] = (r_state == S_LOCKED) && r_lane[i]
                      && phy_rxelecidle_i[i]
                      && (r_idle_cnt[i] == IDLE_LAST);
        end
    end

    // Runs from both ends; lane 0 wins whenever it is present.
    always_comb begin
        w_run0 = '0;
        w_runn = '0;
        w_go0  = 1'b1;
        w_gon  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (w_go0 && r_lane[i]) w_run0 = w_run0 + 6'd1;
            else                    w_go0  = 1'b0;
            if (w_gon && r_lane[N-1-i]) w_runn = w_runn + 6'd1;
            else                        w_gon  = 1'b0;
        end
        w_rev   = (w_run0 == 6'd0) && (w_runn != 6'd0);
        w_run   = w_rev ? w_runn : w_run0;
        w_width = '0;
        for (int k = 0; k < 6; k++) begin
            if ((6'd1 << k) <= w_run) w_width = 6'd1 << k;
        end
        w_keep = '0;
        for (int i = 0; i < N; i++) begin
            w_keep[i] = w_rev ? (i >= N - int'(w_width))
                              : (i < int'(w_width));
        end
        w_trim      = r_lane & w_keep;
        w_nact_trim = '0;
        w_nact_full = '0;
        for (int i = 0; i < N; i++) begin
            if (w_trim[i]) w_nact_trim = 6'(i + 1);
            if (r_lane[i]) w_nact_full = 6'(i + 1);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_rise) w_next = S_COLLECT;
            S_COLLECT: begin
                if (!detect_en_i)           w_next = S_IDLE;
                else if (r_win == WIN_LAST) w_next = S_EVAL;
            end
            S_EVAL:    w_next = (w_width != 6'd0) ? S_LOCKED : S_IDLE;
            S_LOCKED:  if (w_width == 6'd0) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (clear_i) w_next = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en_q  <= 1'b0;
            r_win   <= '0;
            r_lane  <= '0;
            r_width <= '0;
            r_rev   <= 1'b0;
            r_nact  <= '0;
            r_done  <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_en_q <= detect_en_i;
            r_lost <= 1'b0;
            r_done <= (r_state == S_LOCKED) && (w_next == S_LOCKED);
            if (clear_i) begin
                r_win   <= '0;
                r_lane  <= '0;
                r_width <= '0;
                r_rev   <= 1'b0;
                r_nact  <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            r_lane <= '0;
                            r_win  <= '0;
                        end
                    end
                    S_COLLECT: begin
                        if (!detect_en_i) begin
                            r_lane <= '0;
                        end else begin
                            r_lane <= r_lane | w_hit;
                            r_win  <= r_win + 1'b1;
                        end
                    end
                    S_EVAL: begin
                        r_lane  <= w_trim;
                        r_width <= w_width;
                        r_rev   <= w_rev;
                        r_nact  <= w_nact_trim;
                    end
                    S_LOCKED: begin
                        // Width follows the retained lanes one edge later.
                        r_lane  <= r_lane & ~w_drop;
                        r_lost  <= |w_drop;
                        r_width <= w_width;
                        r_rev   <= w_rev;
                        r_nact  <= w_nact_full;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) r_idle_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clear_i || (r_state != S_LOCKED) || !r_lane[i]
                    || !phy_rxelecidle_i[i] || w_drop[i])
                    r_idle_cnt[i] <= '0;
                else
                    r_idle_cnt[i] <= r_idle_cnt[i] + 1'b1;
            end
        end
    end

    assign lane_status_o      = r_lane;
    assign num_active_lanes_o = r_nact;
    assign link_width_o       = r_width;
    assign lane_reversed_o    = r_rev;
    assign detect_done_o      = r_done;
    assign lane_lost_o        = r_lost;

endmodule

// File: doc/pcie_lane_detect_tracker.md
# pcie_lane_detect_tracker

Per-lane receiver-detect collector and link-width negotiator for the PCIe PHY core, generalising the single-register lane-status/active-count logic in the PHY top into a parametrised block. It samples PIPE receiver-detect results in a bounded window and resolves a legal link width, including lane reversal. After lock it monitors electrical idle on active lanes and drops lanes that stay idle. It sits between the PIPE status inputs and the downstream LTSSM, which consumes `lane_status_o`, `num_active_lanes_o` and `link_width_o`.

## Interface
- `MAX_NUM_LANES`, 16: lanes supported; legal values are 1, 2, 4, 8, 16, 32.
- `WINDOW_CYCLES`, 64: length of the detect collection window in clk_i cycles; must be ≥1.
- `IDLE_TIMEOUT`, 1024: number of consecutive `phy_rxelecidle_i` cycles after which an active lane is dropped; must be ≥2.
- `clk_i` input 1: single clock (PIPE RX user clock domain).
- `rst_ni` input 1: asynchronous, active-low reset.
- `clear_i` input 1: synchronous restart, equivalent to a phystatus reset; returns to IDLE.
- `detect_en_i` input 1: level signal; a rising edge opens a collection window.
- `phy_phystatus_i` input MAX_NUM_LANES: PIPE PhyStatus, per lane.
- `phy_rxstatus_i` input 3*MAX_NUM_LANES: PIPE RxStatus; lane i occupies bits [3i+:3].
- `phy_rxelecidle_i` input MAX_NUM_LANES: PIPE RxElecIdle, per lane.
- `lane_status_o` output MAX_NUM_LANES: lanes currently detected and retained.
- `num_active_lanes_o` output 6: index of highest set bit of `lane_status_o` plus 1; 0 if no bit is set.
- `link_width_o` output 6: negotiated legal width: 0, 1, 2, 4, 8, 16 or 32.
- `lane_reversed_o` output 1: width is resolved from lane MAX_NUM_LANES-1 downward.
- `detect_done_o` output 1: high while in LOCKED.
- `lane_lost_o` output 1: one-cycle pulse when any lane is dropped.

## Operation
- States: IDLE, COLLECT, EVAL, LOCKED.
- IDLE:
  - outputs hold their last values, except `detect_done_o`=0;
  - a rising edge of `detect_en_i` (registered compare) clears `lane_status_o` and the window counter, then → COLLECT.
- COLLECT:
  - each cycle, for every lane i with `phy_phystatus_i[i]` && rxstatus[i]==3'b011, set `lane_status_o[i]` (sticky);
  - the window counter increments; when it reaches WINDOW_CYCLES-1, → EVAL;
  - `detect_en_i` low mid-window aborts: clear `lane_status_o`, → IDLE.
- EVAL (one cycle):
  - r0 = run of consecutive set bits starting at lane 0;
  - rN = run of consecutive set bits starting at lane MAX_NUM_LANES-1, counting downward;
  - if r0>0: width = largest power of two ≤ r0, reversed=0;
  - else if rN>0: width = largest power of two ≤ rN, reversed=1;
  - else width=0;
  - lanes outside the chosen run are cleared in `lane_status_o`;
  - width>0 → LOCKED; width==0 → IDLE.
- LOCKED:
  - each active lane has an idle counter; `phy_rxelecidle_i[i]`=1 increments it, 0 zeroes it;
  - when the counter reaches IDLE_TIMEOUT-1 while idle is still asserted, clear the lane bit and pulse `lane_lost_o`;
  - multiple lanes dropping in the same cycle produce a single pulse;
  - width, reversal and num_active are recomputed from the new `lane_status_o` using the EVAL rule in the following cycle;
  - if the recomputed width is 0 → IDLE.
- Idle counters are held at 0 outside LOCKED.
- `clear_i` has priority over every transition: all outputs return to reset values and the state goes to IDLE.
- PhyStatus pulses outside COLLECT are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Detect latency: a `detect_en_i` rising edge sampled at edge k → COLLECT from edge k+1.
- A qualifying PhyStatus sampled at edge t → `lane_status_o` bit visible after edge t.
- EVAL occupies exactly one cycle after the last window cycle; `link_width_o`, `lane_reversed_o` and `num_active_lanes_o` update on the EVAL edge.
- `detect_done_o` rises on the edge after EVAL.
- Lane drop: IDLE_TIMEOUT consecutive idle samples → bit cleared and `lane_lost_o` high on the same edge.
- After a drop, `link_width_o` updates one edge later.
- An idle deassertion on the timeout cycle prevents the drop.
- Asynchronous reset mid-window or while LOCKED takes effect immediately; the block restarts only on a fresh `detect_en_i` rising edge.

## Test plan
- MAX_NUM_LANES=4, WINDOW_CYCLES=8; PhyStatus/rxstatus=011 on lanes 0–3 during COLLECT → `lane_status_o`=4'b1111, width 4, reversed 0, num_active 4, `detect_done_o`=1 ten cycles after the enable edge.
- Lanes 0, 1, 2 detected → width 2, `lane_status_o`=4'b0011, num_active 2.
- Lanes 3, 2 detected (not lane 0) → reversed 1, width 2, `lane_status_o`=4'b1100, num_active 4.
- Lanes 0–3 locked, IDLE_TIMEOUT=16; lane 3 idle for 16 cycles → `lane_lost_o` single pulse, `lane_status_o`=4'b0111, width 2 one cycle later.
- Lane 3 idle for 15 cycles, then deasserted → no drop.
- Mid-COLLECT, `detect_en_i` falls → `lane_status_o`=0, state IDLE.
- With `clear_i` asserted in the same cycle as a drop → all outputs 0, no `lane_lost_o` pulse.
- No lane detected → width 0, `detect_done_o` stays 0, state returns to IDLE.
